// File: rtl/ex_issue_ctrl_if.sv
// Decode, execute and writeback signal bundle for the issue controller.
interface ex_issue_ctrl_if;
  logic       dec_valid;
  logic       dec_ready;
  logic [3:0] dec_alu_control;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic [4:0] dec_rd;
  logic       dec_reg_write;
  logic       ex_valid;
  logic [3:0] ex_alu_control;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       wb_valid;
  logic [4:0] wb_rd;

  modport master (
    output dec_valid, dec_alu_control, dec_rs1, dec_rs2, dec_rd, dec_reg_write,
    output wb_valid, wb_rd,
    input  dec_ready, ex_valid, ex_alu_control, ex_rs1, ex_rs2, ex_rd, ex_reg_write
  );

  modport slave (
    input  dec_valid, dec_alu_control, dec_rs1, dec_rs2, dec_rd, dec_reg_write,
    input  wb_valid, wb_rd,
    output dec_ready, ex_valid, ex_alu_control, ex_rs1, ex_rs2, ex_rd, ex_reg_write
  );
endinterface

// File: rtl/ex_issue_ctrl.sv
// Issue sequencer: scoreboard-based RAW/WAW stall, post-jump drain and a
// registered single-cycle issue pulse to execute.
module ex_issue_ctrl #(
  parameter int NUM_REGS       = 32,
  parameter int JUMP_DRAIN_CYC = 2,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ex_issue_ctrl_if.slave         bus,
  output logic                   jump_pending,
  output logic                   illegal_op,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int DW = $clog2(JUMP_DRAIN_CYC + 2);

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_ADDI = 4'b0010,
    OP_JUMP = 4'b0011
  } op_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [DW-1:0]         r_cnt, w_cnt_nxt;
  logic [NUM_REGS-1:0]   r_sb, w_sb_nxt;
  logic                  r_ex_valid;
  logic [3:0]            r_ex_alu_control;
  logic [4:0]            r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic                  r_ex_reg_write;
  logic                  r_illegal;
  logic [STALL_CNT_W-1:0] r_stall;

  logic w_uses_rs1, w_uses_rs2, w_is_issue, w_is_jump, w_is_illegal;
  logic w_hazard, w_dec_ready, w_accept;

  // Op decode: which sources are read and whether the op reaches execute.
  always_comb begin
    w_uses_rs1   = 1'b0;
    w_uses_rs2   = 1'b0;
    w_is_issue   = 1'b0;
    w_is_jump    = 1'b0;
    w_is_illegal = 1'b0;
    case (bus.dec_alu_control)
      OP_NOP:  ;
      OP_ADD:  begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_is_issue = 1'b1; end
      OP_ADDI: begin w_uses_rs1 = 1'b1; w_is_issue = 1'b1; end
      OP_JUMP: begin w_is_issue = 1'b1; w_is_jump = 1'b1; end
      default: w_is_illegal = 1'b1;
    endcase
  end

  // Hazards look only at the registered scoreboard; r0 is never pending.
  always_comb begin
    w_hazard = 1'b0;
    if (w_uses_rs1 && bus.dec_rs1 != '0 && r_sb[bus.dec_rs1]) w_hazard = 1'b1;
    if (w_uses_rs2 && bus.dec_rs2 != '0 && r_sb[bus.dec_rs2]) w_hazard = 1'b1;
    if (bus.dec_reg_write && bus.dec_rd != '0 && r_sb[bus.dec_rd]) w_hazard = 1'b1;
    w_dec_ready = (r_state == S_RUN) && !w_hazard;
    w_accept    = bus.dec_valid && w_dec_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (w_accept && w_is_jump && JUMP_DRAIN_CYC > 0) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = DW'(JUMP_DRAIN_CYC);
        end
      end
      S_DRAIN: begin
        w_cnt_nxt = r_cnt - DW'(1);
        if (r_cnt <= DW'(1)) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Clear before set so a same-cycle retire and new write leaves the bit set.
  always_comb begin
    w_sb_nxt = r_sb;
    if (bus.wb_valid && bus.wb_rd != '0) w_sb_nxt[bus.wb_rd] = 1'b0;
    if (w_accept && w_is_issue && bus.dec_reg_write && bus.dec_rd != '0)
      w_sb_nxt[bus.dec_rd] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_sb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sb    <= w_sb_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid       <= 1'b0;
      r_ex_alu_control <= '0;
      r_ex_rs1         <= '0;
      r_ex_rs2         <= '0;
      r_ex_rd          <= '0;
      r_ex_reg_write   <= 1'b0;
      r_illegal        <= 1'b0;
      r_stall          <= '0;
    end else begin
      r_ex_valid <= w_accept && w_is_issue;
      r_illegal  <= w_accept && w_is_illegal;
      if (w_accept && w_is_issue) begin
        r_ex_alu_control <= bus.dec_alu_control;
        r_ex_rs1         <= bus.dec_rs1;
        r_ex_rs2         <= bus.dec_rs2;
        r_ex_rd          <= bus.dec_rd;
        r_ex_reg_write   <= bus.dec_reg_write;
      end
      if (bus.dec_valid && !w_dec_ready && r_stall != '1)
        r_stall <= r_stall + STALL_CNT_W'(1);
    end
  end

  assign bus.dec_ready      = w_dec_ready;
  assign bus.ex_valid       = r_ex_valid;
  assign bus.ex_alu_control = r_ex_alu_control;
  assign bus.ex_rs1         = r_ex_rs1;
  assign bus.ex_rs2         = r_ex_rs2;
  assign bus.ex_rd          = r_ex_rd;
  assign bus.ex_reg_write   = r_ex_reg_write;
  assign jump_pending       = (r_state == S_DRAIN);
  assign illegal_op         = r_illegal;
  assign stall_cnt          = r_stall;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Self-checking bench for ex_issue_ctrl: directed scenarios plus random
// traffic, compared every cycle against a pending-set / drain-countdown model.
module tb_ex_issue_ctrl;
  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_pending;
  logic        illegal_op;
  logic [15:0] stall_cnt;

  ex_issue_ctrl_if bus ();

  ex_issue_ctrl #(
    .NUM_REGS       (32),
    .JUMP_DRAIN_CYC (DRAIN),
    .STALL_CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .jump_pending (jump_pending),
    .illegal_op   (illegal_op),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  bit          m_pend[32];
  int          m_drain;
  int          m_stall;
  bit          m_exv, m_ill;
  logic [3:0]  m_code;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  bit          m_rw;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_drain = 0;
    m_stall = 0;
    m_exv   = 1'b0;
    m_ill   = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.dec_valid = 1'b0; bus.dec_alu_control = '0; bus.dec_rs1 = '0;
    bus.dec_rs2 = '0; bus.dec_rd = '0; bus.dec_reg_write = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready,
  // advance the model, wait for the edge.
  task automatic step(input bit v, input logic [3:0] c, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] d, input bit rw,
                      input bit wv, input logic [4:0] wr);
    bit haz, rdy, acc;
    check_eq("ex_valid", bus.ex_valid, m_exv);
    if (m_exv) begin
      check_eq("ex_alu_control", bus.ex_alu_control, m_code);
      check_eq("ex_rs1", bus.ex_rs1, m_rs1);
      check_eq("ex_rs2", bus.ex_rs2, m_rs2);
      check_eq("ex_rd", bus.ex_rd, m_rd);
      check_eq("ex_reg_write", bus.ex_reg_write, m_rw);
    end
    check_eq("illegal_op", illegal_op, m_ill);
    check_eq("stall_cnt", stall_cnt, m_stall);
    check_eq("jump_pending", jump_pending, m_drain > 0);

    bus.dec_valid = v; bus.dec_alu_control = c; bus.dec_rs1 = s1;
    bus.dec_rs2 = s2; bus.dec_rd = d; bus.dec_reg_write = rw;
    bus.wb_valid = wv; bus.wb_rd = wr;
    #1;
    haz = ((c == 4'd1 || c == 4'd2) && s1 != 0 && m_pend[s1]) ||
          (c == 4'd1 && s2 != 0 && m_pend[s2]) ||
          (rw && d != 0 && m_pend[d]);
    rdy = (m_drain == 0) && !haz;
    check_eq("dec_ready", bus.dec_ready, rdy);
    acc = v && rdy;

    m_exv = acc && (c >= 4'd1 && c <= 4'd3);
    m_ill = acc && (c > 4'd3);
    if (m_exv) begin
      m_code = c; m_rs1 = s1; m_rs2 = s2; m_rd = d; m_rw = rw;
    end
    if (v && !rdy && m_stall < 65535) m_stall++;
    if (wv && wr != 0) m_pend[wr] = 1'b0;
    if (m_exv && rw && d != 0) m_pend[d] = 1'b1;
    if (m_drain > 0) m_drain--;
    else if (acc && c == 4'd3) m_drain = DRAIN;

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_eq("rst_ex_valid", bus.ex_valid, 0);
    check_eq("rst_ex_fields", {bus.ex_alu_control, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_reg_write}, 0);
    check_eq("rst_jump_pending", jump_pending, 0);
    check_eq("rst_illegal", illegal_op, 0);
    check_eq("rst_stall", stall_cnt, 0);
  endtask

  task automatic nop_cycle(input bit wv = 0, input logic [4:0] wr = 0);
    step(0, 4'd0, 0, 0, 0, 0, wv, wr);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Independent back-to-back issue
    step(1, 4'd1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
    step(1, 4'd2, 5'd4, 5'd0, 5'd5, 1, 0, 0);
    nop_cycle();

    // RAW on r3, released by writeback
    repeat (3) step(1, 4'd1, 5'd3, 5'd0, 5'd6, 1, 0, 0);
    step(1, 4'd1, 5'd3, 5'd0, 5'd6, 1, 1, 5'd3);
    step(1, 4'd1, 5'd3, 5'd0, 5'd6, 1, 0, 0);
    nop_cycle();

    // WAW on r7 and same-cycle set/clear
    step(1, 4'd2, 5'd0, 5'd0, 5'd7, 1, 0, 0);
    step(1, 4'd2, 5'd0, 5'd0, 5'd7, 1, 1, 5'd7);
    step(1, 4'd2, 5'd0, 5'd0, 5'd7, 1, 1, 5'd7);
    repeat (2) step(1, 4'd1, 5'd7, 5'd0, 5'd8, 0, 0, 0);
    step(1, 4'd1, 5'd7, 5'd0, 5'd8, 0, 1, 5'd7);
    step(1, 4'd1, 5'd7, 5'd0, 5'd8, 0, 0, 0);
    nop_cycle();

    // Jump drain with an ADD waiting behind it
    step(1, 4'd3, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    repeat (3) step(1, 4'd1, 5'd10, 5'd11, 5'd12, 0, 0, 0);
    nop_cycle();

    // Illegal, NOP, r0
    step(1, 4'd7, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    step(1, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(1, 4'd1, 5'd1, 5'd2, 5'd0, 1, 0, 0);
    step(1, 4'd1, 5'd0, 5'd0, 5'd9, 0, 0, 0);
    nop_cycle();

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] c;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      c = (sel < 4) ? 4'd1 : (sel < 7) ? 4'd2 : (sel == 7) ? 4'd3 :
          (sel == 8) ? 4'd0 : 4'($urandom_range(4, 15));
      step($urandom_range(0, 3) != 0, c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
    end
    nop_cycle();

    // Reset during drain with pending bits
    step(1, 4'd1, 5'd0, 5'd0, 5'd20, 1, 0, 0);
    step(1, 4'd3, 5'd0, 5'd0, 5'd21, 1, 0, 0);
    step(1, 4'd1, 5'd20, 5'd21, 5'd22, 1, 0, 0);
    do_reset();
    step(1, 4'd1, 5'd20, 5'd21, 5'd22, 1, 0, 0);
    nop_cycle();

    // Stall counter saturation
    do_reset();
    step(1, 4'd1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    repeat (70000) step(1, 4'd1, 5'd3, 5'd0, 5'd4, 0, 0, 0);
    nop_cycle();
    check_eq("stall_saturated", stall_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
